// File: rtl/hcsr04_trig_seq_if.sv
// hcsr04_trig_seq_if
//   Control/status bundle between a sequencer controller and the HC-SR04
//   trigger sequencer.
//   master : drives en, mode, start, period; observes trig, ch_sel, busy,
//            frame_done.
//   slave  : the sequencer itself (mirror of master).
interface hcsr04_trig_seq_if #(
  parameter int N_CH  = 4,
  parameter int CH_W  = 2,
  parameter int CNT_W = 19
);
  logic             en;
  logic             mode;
  logic             start;
  logic [CNT_W-1:0] period;
  logic [N_CH-1:0]  trig;
  logic [CH_W-1:0]  ch_sel;
  logic             busy;
  logic             frame_done;

  modport master (
    output en, mode, start, period,
    input  trig, ch_sel, busy, frame_done
  );

  modport slave (
    input  en, mode, start, period,
    output trig, ch_sel, busy, frame_done
  );
endinterface

// File: rtl/hcsr04_trig_seq.sv
// hcsr04_trig_seq
//   Time-multiplexed trigger sequencer for N_CH HC-SR04 rangers. Each slot
//   fires one channel for PULSE_US cycles, then waits out the rest of the
//   slot length; channels are visited 0..N_CH-1 either continuously or once
//   per start request.
// Ports:
//   clk_us : 1 MHz clock, rising edge
//   rstn   : asynchronous active-low reset
//   bus    : slave side of hcsr04_trig_seq_if (en, mode, start, period in;
//            trig, ch_sel, busy, frame_done out, all registered)
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | not sequencing; waiting for en (+start in single mode)
// S_PULSE | trig[ch_sel] high, cnt 0 .. PULSE_US-1
// S_WAIT  | trig low, cnt PULSE_US .. p_eff-1
module hcsr04_trig_seq #(
  parameter int N_CH     = 4,
  parameter int CH_W     = 2,
  parameter int CNT_W    = 19,
  parameter int PULSE_US = 15
) (
  input  logic                clk_us,
  input  logic                rstn,
  hcsr04_trig_seq_if.slave    bus
);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT} state_t;

  localparam logic [CNT_W-1:0] P_MIN     = CNT_W'(PULSE_US + 1);
  localparam logic [CNT_W-1:0] PULSE_END = CNT_W'(PULSE_US - 1);
  localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_CH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] p_eff_q, p_eff_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [N_CH-1:0]  trig_q, trig_d;
  logic             fd_q, fd_d;
  logic [CNT_W-1:0] p_new;

  // Slot length is clamped so the WAIT phase is always at least one cycle.
  assign p_new = (bus.period < P_MIN) ? P_MIN : bus.period;

  function automatic logic [N_CH-1:0] onehot(input logic [CH_W-1:0] idx);
    return N_CH'(1) << idx;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_eff_d = p_eff_q;
    ch_d    = ch_q;
    trig_d  = '0;
    fd_d    = 1'b0;

    if (!bus.en) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      ch_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!bus.mode || bus.start) begin
            state_d = S_PULSE;
            cnt_d   = '0;
            ch_d    = '0;
            p_eff_d = p_new;
            trig_d  = onehot('0);
          end
        end

        S_PULSE: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == PULSE_END) begin
            state_d = S_WAIT;
          end else begin
            trig_d = onehot(ch_q);
          end
        end

        S_WAIT: begin
          if (cnt_q == p_eff_q - CNT_W'(1)) begin
            cnt_d = '0;
            if (ch_q == CH_LAST) begin
              fd_d = 1'b1;
              if (bus.mode) begin
                // ch_sel holds at the last channel until the next start
                state_d = S_IDLE;
              end else begin
                state_d = S_PULSE;
                ch_d    = '0;
                p_eff_d = p_new;
                trig_d  = onehot('0);
              end
            end else begin
              state_d = S_PULSE;
              ch_d    = ch_q + CH_W'(1);
              p_eff_d = p_new;
              trig_d  = onehot(ch_q + CH_W'(1));
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          ch_d    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_us or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p_eff_q <= P_MIN;
      ch_q    <= '0;
      trig_q  <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_eff_q <= p_eff_d;
      ch_q    <= ch_d;
      trig_q  <= trig_d;
      fd_q    <= fd_d;
    end
  end

  assign bus.trig       = trig_q;
  assign bus.ch_sel     = ch_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_hcsr04_trig_seq.sv
module tb_hcsr04_trig_seq;
  localparam int N_CH     = 4;
  localparam int CH_W     = 2;
  localparam int CNT_W    = 19;
  localparam int PULSE_US = 15;
  localparam int OW       = N_CH + CH_W + 2;

  logic clk_us = 1'b0;
  logic rstn   = 1'b0;
  int   total  = 0;
  int   bad    = 0;

  hcsr04_trig_seq_if #(.N_CH(N_CH), .CH_W(CH_W), .CNT_W(CNT_W)) bus ();

  hcsr04_trig_seq #(.N_CH(N_CH), .CH_W(CH_W), .CNT_W(CNT_W), .PULSE_US(PULSE_US)) dut (
    .clk_us (clk_us),
    .rstn   (rstn),
    .bus    (bus)
  );

  always #5 clk_us = ~clk_us;

  // Reference model: a slot is described by its channel, its latched length
  // and the cycles elapsed since it began; trig is high for the first
  // PULSE_US cycles of each slot.
  bit m_act;
  int m_ch, m_pe, m_el;
  bit m_fd;

  function automatic void model_reset();
    m_act = 0; m_ch = 0; m_pe = PULSE_US + 1; m_el = 0; m_fd = 0;
  endfunction

  function automatic int clamp_p(input int p);
    return (p < PULSE_US + 1) ? PULSE_US + 1 : p;
  endfunction

  function automatic void model_step();
    m_fd = 0;
    if (!bus.en) begin
      m_act = 0; m_ch = 0; m_el = 0;
    end else if (!m_act) begin
      if (!bus.mode || bus.start) begin
        m_act = 1; m_ch = 0; m_el = 0; m_pe = clamp_p(int'(bus.period));
      end
    end else begin
      m_el++;
      if (m_el == m_pe) begin
        m_el = 0;
        if (m_ch == N_CH - 1) begin
          m_fd = 1;
          if (bus.mode) m_act = 0;
          else begin m_ch = 0; m_pe = clamp_p(int'(bus.period)); end
        end else begin
          m_ch++; m_pe = clamp_p(int'(bus.period));
        end
      end
    end
  endfunction

  function automatic logic [OW-1:0] expv();
    logic [N_CH-1:0] t;
    t = (m_act && m_el < PULSE_US) ? (N_CH'(1) << m_ch) : '0;
    return {t, CH_W'(m_ch), m_act, m_fd};
  endfunction

  function automatic logic [OW-1:0] obs();
    return {bus.trig, bus.ch_sel, bus.busy, bus.frame_done};
  endfunction

  task automatic cyc();
    @(posedge clk_us);
    model_step();
    #1;
  endtask

  task automatic go_idle();
    @(negedge clk_us);
    bus.en = 0; bus.mode = 0; bus.start = 0;
    cyc(); cyc();
  endtask

  task automatic test_reset();
    bus.en = 0; bus.mode = 0; bus.start = 0; bus.period = 19'd100;
    model_reset();
    #3;
    total++;
    if (obs() !== '0) begin
      bad++; $display("FAIL reset_async got=%b exp=%b", obs(), {OW{1'b0}});
    end
    @(negedge clk_us); rstn = 1;
    for (int c = 0; c < 3; c++) begin
      cyc(); total++;
      if (obs() !== expv()) begin
        bad++; $display("FAIL reset_idle c=%0d got=%b exp=%b", c, obs(), expv());
      end
    end
  endtask

  task automatic test_continuous();
    int hi;
    hi = 0;
    go_idle();
    @(negedge clk_us); bus.en = 1; bus.mode = 0; bus.period = 19'd100;
    for (int c = 0; c < 850; c++) begin
      cyc(); total++;
      if (obs() !== expv()) begin
        bad++; $display("FAIL cont c=%0d got=%b exp=%b", c, obs(), expv());
      end
      if (c < 100 && bus.trig[0]) hi++;
      if (c == 100 || c == 400 || c == 800) begin
        total++;
        if (bus.trig !== ((c == 100) ? 4'b0010 : 4'b0001) || bus.frame_done !== (c != 100)) begin
          bad++; $display("FAIL cont_edge c=%0d trig=%b fd=%b", c, bus.trig, bus.frame_done);
        end
      end
    end
    total++;
    if (hi !== PULSE_US) begin
      bad++; $display("FAIL cont_width got=%0d exp=%0d", hi, PULSE_US);
    end
  endtask

  task automatic test_single();
    go_idle();
    @(negedge clk_us); bus.en = 1; bus.mode = 1; bus.period = 19'd50;
    for (int rep = 0; rep < 2; rep++) begin
      @(negedge clk_us); bus.start = 1;
      for (int c = 0; c < 230; c++) begin
        cyc();
        if (c == 0) begin @(negedge clk_us); bus.start = 0; end
        total++;
        if (obs() !== expv()) begin
          bad++; $display("FAIL single r=%0d c=%0d got=%b exp=%b", rep, c, obs(), expv());
        end
        if (c == 200) begin
          total++;
          if (bus.busy !== 1'b0 || bus.frame_done !== 1'b1 || bus.ch_sel !== 2'd3) begin
            bad++; $display("FAIL single_end busy=%b fd=%b ch=%0d exp busy=0 fd=1 ch=3", bus.busy, bus.frame_done, bus.ch_sel);
          end
        end
      end
    end
  endtask

  task automatic test_min_period();
    go_idle();
    @(negedge clk_us); bus.en = 1; bus.mode = 0; bus.period = 19'd5;
    for (int c = 0; c < 140; c++) begin
      cyc(); total++;
      if (obs() !== expv()) begin
        bad++; $display("FAIL minp c=%0d got=%b exp=%b", c, obs(), expv());
      end
      if (c == 15 || c == 16 || c == 64) begin
        total++;
        if (bus.trig !== ((c == 15) ? 4'b0000 : (c == 16) ? 4'b0010 : 4'b0001)) begin
          bad++; $display("FAIL minp_edge c=%0d trig=%b", c, bus.trig);
        end
      end
    end
  endtask

  task automatic test_en_abort();
    go_idle();
    @(negedge clk_us); bus.en = 1; bus.mode = 0; bus.period = 19'd100;
    for (int c = 0; c < 230; c++) begin
      cyc();
      if (c == 206) begin @(negedge clk_us); bus.en = 0; end
      if (c == 215) begin @(negedge clk_us); bus.en = 1; end
      total++;
      if (obs() !== expv()) begin
        bad++; $display("FAIL abort c=%0d got=%b exp=%b", c, obs(), expv());
      end
      if (c == 207 || c == 216) begin
        total++;
        if (obs() !== ((c == 207) ? 8'b0000_00_0_0 : 8'b0001_00_1_0)) begin
          bad++; $display("FAIL abort_edge c=%0d got=%b", c, obs());
        end
      end
    end
  endtask

  task automatic test_period_change();
    go_idle();
    @(negedge clk_us); bus.en = 1; bus.mode = 0; bus.period = 19'd100;
    for (int c = 0; c < 520; c++) begin
      cyc();
      if (c == 150) begin @(negedge clk_us); bus.period = 19'd300; end
      total++;
      if (obs() !== expv()) begin
        bad++; $display("FAIL pchg c=%0d got=%b exp=%b", c, obs(), expv());
      end
      if (c == 200 || c == 499 || c == 500) begin
        total++;
        if (bus.trig !== ((c == 200) ? 4'b0100 : (c == 499) ? 4'b0000 : 4'b1000)) begin
          bad++; $display("FAIL pchg_edge c=%0d trig=%b", c, bus.trig);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    go_idle();
    @(negedge clk_us); bus.en = 1; bus.mode = 0; bus.period = 19'd40;
    for (int c = 0; c < 5; c++) cyc();
    #2 rstn = 0;
    model_reset();
    #1 total++;
    if (obs() !== '0) begin
      bad++; $display("FAIL areset_mid got=%b exp=%b", obs(), {OW{1'b0}});
    end
    @(negedge clk_us); rstn = 1;
    for (int c = 0; c < 60; c++) begin
      cyc(); total++;
      if (obs() !== expv()) begin
        bad++; $display("FAIL areset c=%0d got=%b exp=%b", c, obs(), expv());
      end
      if (c == 0) begin
        total++;
        if (bus.trig !== 4'b0001) begin
          bad++; $display("FAIL areset_first trig=%b exp=0001", bus.trig);
        end
      end
    end
  endtask

  task automatic test_random();
    go_idle();
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk_us);
      bus.en     = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 299) == 0) bus.mode = ~bus.mode;
      bus.start  = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 49) == 0) bus.period = 19'($urandom_range(1, 60));
      cyc(); total++;
      if (obs() !== expv()) begin
        bad++; $display("FAIL rand c=%0d got=%b exp=%b", c, obs(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_single();
    test_min_period();
    test_en_abort();
    test_period_change();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hcsr04_trig_seq.md
# hcsr04_trig_seq

Multi-channel trigger sequencer for HC-SR04 ultrasonic rangers, driven from the 1 MHz `clk_us` tick. It time-multiplexes N sensors so that only one sensor fires per slot, which prevents acoustic crosstalk between sensors. The slot period is set at runtime, and the block runs either continuously in round-robin or as a single frame on command. It sits between the `clk_us` divider and the per-channel echo-measurement blocks. `ch_sel` and `frame_done` tell the echo logic which sensor is live.

## Interface
- `N_CH`, 4: number of sensor channels (1..16).
- `CH_W`, 2: width of `ch_sel`; must satisfy 2^CH_W ≥ N_CH.
- `CNT_W`, 19: width of the slot counter and of `period`.
- `PULSE_US`, 15: trigger high time in `clk_us` cycles (≥ 10 per the sensor datasheet).

- `clk_us`  in  1  1 MHz clock; all logic on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `en`  in  1  block enable; low forces IDLE.
- `mode`  in  1  0 = continuous round-robin, 1 = single frame per `start`.
- `start`  in  1  single-frame request; sampled only in IDLE with `en`=1 and `mode`=1.
- `period`  in  CNT_W  slot length in cycles; sampled at the start of each slot.
- `trig`  out  N_CH  one-hot trigger pulses, registered.
- `ch_sel`  out  CH_W  index of the active or most recent channel.
- `busy`  out  1  high whenever the state is not IDLE.
- `frame_done`  out  1  one-cycle pulse at the end of the slot of channel N_CH-1.

## Operation
- States are IDLE, PULSE and WAIT. A slot is one PULSE phase followed by one WAIT phase.
- Reset values: state=IDLE, `cnt`=0, `ch_sel`=0, `trig`=0, `busy`=0, `frame_done`=0.
- Leaving IDLE to PULSE with `cnt`=0 and `ch_sel`=0 happens when either condition holds:
  - `en`=1 and `mode`=0, or
  - `en`=1, `mode`=1 and `start`=1.
- Slot start:
  - `p_eff` = max(`period`, PULSE_US+1), latched into a CNT_W register.
  - A `period` change mid-slot has no effect until the next slot.
- PULSE: `trig[ch_sel]`=1 and all other bits are 0. `cnt` increments each cycle. When `cnt`=PULSE_US-1 the state moves to WAIT.
- WAIT: `trig`=0. `cnt` increments each cycle. When `cnt`=`p_eff`-1 the slot ends and `cnt` returns to 0.
- Slot end with `ch_sel` < N_CH-1: `ch_sel`+1, back to PULSE.
- Slot end with `ch_sel` = N_CH-1:
  - `frame_done`=1 for one cycle.
  - If `mode`=0 (sampled at this edge), `ch_sel` wraps to 0 and the state returns to PULSE.
  - If `mode`=1, the state goes to IDLE and `ch_sel` holds at N_CH-1 until the next start.
- `en`=0 in any state: next cycle gives state=IDLE, `trig`=0, `cnt`=0, `ch_sel`=0, `frame_done`=0. A frame in progress is aborted with no `frame_done`.
- `start` asserted while busy, or while `mode`=0, is ignored. Requests are not queued.
- A `mode` change mid-frame takes effect only at the frame boundary.
- N_CH=1: `ch_sel` stays 0 and `frame_done` fires every slot.
- The counter never overflows: `p_eff` ≤ 2^CNT_W-1 by construction.
- Asynchronous reset mid-pulse drives `trig` low immediately.

## Timing
- Edge numbering: the qualifying condition is sampled at edge k.
  - From edge k+1: `busy`=1 and `trig[0]`=1.
  - `trig[0]` stays high for exactly PULSE_US cycles, edges k+1 through k+PULSE_US.
- Slot length is exactly `p_eff` cycles. Trigger rising edges of consecutive channels are `p_eff` apart.
- Full frame is N_CH×`p_eff` cycles.
- `frame_done` is high in the cycle after the last WAIT cycle of channel N_CH-1. In continuous mode it coincides with `trig[0]` rising again.
- Single mode: `busy` falls in the same cycle `frame_done` rises.
- `trig`, `ch_sel`, `busy` and `frame_done` are all registered, with no combinational input-to-output paths.

## Test plan
- Continuous, `period`=100, N_CH=4 → `trig[0..3]` each high for 15 cycles. Rising edges at 0/100/200/300, then `trig[0]` again at 400. `frame_done` pulses at 400, 800, ….
- Single, `period`=50, `start` pulse → exactly one frame of 200 cycles. `busy` falls at 200 with `frame_done`=1. `trig` stays 0 afterward; a second `start` repeats the frame.
- `period`=5 (below minimum) → `p_eff`=16: 15 cycles high, 1 cycle low per slot, frame = 64 cycles.
- `en` dropped at cycle 7 of `trig[2]` → `trig`=0, `busy`=0, `ch_sel`=0 the next cycle, with no `frame_done`. Re-enabling starts again at channel 0.
- `period` changed from 100 to 300 mid-slot of channel 1 → channel 1 slot stays 100 cycles; channel 2 slot is 300 cycles.
- `rstn` asserted during PULSE → all outputs 0 asynchronously. After release with `en`=1 and `mode`=0, `trig[0]` rises at the first edge.
